// File: rtl/sync_fifo_param_pkg.sv
// Shared package for the single-clock parametrised FIFO.
// Holds width helpers and default parameter values used by the FIFO,
// its bus interface and the wrapping pointer sub-module.
// Optional build macro used by the FIFO: SYNC_FIFO_FWFT_EN (first-word-fall-through read).
package sync_fifo_pkg;

  localparam int DEF_N        = 8;
  localparam int DEF_DEPTH    = 90;
  localparam int DEF_AF_LEVEL = 80;
  localparam int DEF_AE_LEVEL = 8;

  // Pointer width: enough bits to address DEPTH entries, never below one bit.
  function automatic int clog2_min1(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  // Count width: must represent 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Bus interface for sync_fifo_param: write port, read port and status.
// Handshake: a write is taken on a rising edge when wr_en=1 and fifo_Full=0;
// a read is taken when rd_en=1 and fifo_Empty=0. There is no back-pressure
// beyond the registered Full/Empty flags; requests made against the wrong
// flag are dropped and recorded in the sticky overflow/underflow bits.
// In standard mode rd_valid marks the single cycle in which rd_data holds a
// popped word; in first-word-fall-through mode (SYNC_FIFO_FWFT_EN) rd_valid
// means rd_data shows the current head, and rd_en acknowledges it.
interface sync_fifo_param_if
  import sync_fifo_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int CW = cnt_w(DEF_DEPTH)
);

  logic          wr_en;
  logic [N-1:0]  wr_data;
  logic          rd_en;
  logic [N-1:0]  rd_data;
  logic          rd_valid;
  logic          fifo_Full;
  logic          fifo_Empty;
  logic          almost_full;
  logic          almost_empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  // Producer/consumer side: drives requests, observes data and status.
  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, fifo_Full, fifo_Empty,
    input  almost_full, almost_empty, count, overflow, underflow
  );

  // FIFO side: consumes requests, drives data and status.
  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, fifo_Full, fifo_Empty,
    output almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_param_ptr.sv
// Wrapping pointer for sync_fifo_param.
// Counts 0..DEPTH-1 and wraps explicitly at DEPTH-1, so non-power-of-2
// depths never step into unused addresses. clr returns it to 0.
module fifo_wrap_ptr #(
  parameter int DEPTH = 90,
  parameter int PW    = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Next pointer: flush wins, otherwise advance with explicit wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      if (ptr_q == PW'(DEPTH - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + PW'(1);
      end
    end
  end

  // Pointer register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost-full /
// almost-empty thresholds, sticky overflow/underflow and synchronous flush.
// Any DEPTH >= 2 is supported; pointers wrap explicitly at DEPTH-1.
// Build macro SYNC_FIFO_FWFT_EN selects first-word-fall-through reads;
// without it reads have one cycle of registered latency.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEF_AF_LEVEL,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  sync_fifo_param_if.slave bus
);

  localparam int PW = clog2_min1(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  // Storage; contents deliberately not reset.
  logic [N-1:0]  mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic          wr_acc;
  logic          rd_acc;

  // Acceptance uses the registered flags; a flush suppresses both ports.
  always_comb begin
    wr_acc = bus.wr_en & ~full_q  & ~clr;
    rd_acc = bus.rd_en & ~empty_q & ~clr;
  end

  fifo_wrap_ptr #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (wr_acc),
    .ptr (wr_ptr)
  );

  fifo_wrap_ptr #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (rd_acc),
    .ptr (rd_ptr)
  );

  // Storage write on an accepted write request.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // Next occupancy and flags; flags come from the next count so they line
  // up with the count register with no extra cycle of lag.
  always_comb begin
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (clr) begin
      count_d = '0;
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
    af_d    = (count_d >= CW'(AF_LEVEL));
    ae_d    = (count_d <= CW'(AE_LEVEL));
  end

  // Sticky error bits: any request against the wrong flag sets them,
  // only reset or flush clears them.
  always_comb begin
    ovf_d = ovf_q | (bus.wr_en & full_q);
    udf_d = udf_q | (bus.rd_en & empty_q);
    if (clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
  end

  // Occupancy, flag and error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN

  // Head of the queue is always visible; rd_en just pops it.
  always_comb begin
    bus.rd_data  = mem[rd_ptr];
    bus.rd_valid = ~empty_q;
  end

`else

  logic [N-1:0] rd_data_q, rd_data_d;
  logic         rd_valid_q, rd_valid_d;

  // Registered read: capture the head on accept, otherwise hold.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_acc;
    if (rd_acc) begin
      rd_data_d = mem[rd_ptr];
    end
  end

  // Read data/valid registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Drive the registered read port onto the bus.
  always_comb begin
    bus.rd_data  = rd_data_q;
    bus.rd_valid = rd_valid_q;
  end

`endif

  // Status outputs straight from registers.
  always_comb begin
    bus.fifo_Full    = full_q;
    bus.fifo_Empty   = empty_q;
    bus.almost_full  = af_q;
    bus.almost_empty = ae_q;
    bus.count        = count_q;
    bus.overflow     = ovf_q;
    bus.underflow    = udf_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (N=8, DEPTH=90).
// Covers reset, fill to full, overflow, ordered drain, underflow, pointer
// wrap under steady traffic, full/empty simultaneous requests, flush and
// asynchronous reset mid-burst. With SYNC_FIFO_FWFT_EN defined the read
// checks follow first-word-fall-through timing.
module tb_sync_fifo_param;

  localparam int N     = 8;
  localparam int DEPTH = 90;
  localparam int AF    = 80;
  localparam int AE    = 8;
  localparam int CW    = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] exp_q[$];

  sync_fifo_param_if #(.N(N), .CW(CW)) bus ();

  sync_fifo_param #(
    .N        (N),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs settle before the edge, outputs sampled 1ns after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Status checks against the scoreboard occupancy.
  task automatic check_status(input string tag);
    int sz;
    sz = exp_q.size();
    check({tag, "_count"}, 32'(bus.count), sz);
    check({tag, "_empty"}, 32'(bus.fifo_Empty), (sz == 0) ? 1 : 0);
    check({tag, "_full"},  32'(bus.fifo_Full), (sz == DEPTH) ? 1 : 0);
    check({tag, "_af"},    32'(bus.almost_full), (sz >= AF) ? 1 : 0);
    check({tag, "_ae"},    32'(bus.almost_empty), (sz <= AE) ? 1 : 0);
  endtask

  // Drive one cycle of requests and check the read port and status.
  task automatic drive(input logic w, input logic [N-1:0] d, input logic r);
    logic rd_ok;
    logic wr_ok;
    logic [N-1:0] got;
    rd_ok = r && (exp_q.size() > 0);
    wr_ok = w && (exp_q.size() < DEPTH);
    got   = '0;
`ifdef SYNC_FIFO_FWFT_EN
    if (rd_ok) begin
      check("fwft_head_valid", 32'(bus.rd_valid), 1);
      check("fwft_head_data", 32'(bus.rd_data), 32'(exp_q[0]));
    end
`endif
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = r;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    if (rd_ok) got = exp_q.pop_front();
    if (wr_ok) exp_q.push_back(d);
`ifdef SYNC_FIFO_FWFT_EN
    check("rd_valid", 32'(bus.rd_valid), (exp_q.size() != 0) ? 1 : 0);
`else
    check("rd_valid", 32'(bus.rd_valid), rd_ok ? 1 : 0);
    if (rd_ok) check("rd_data", 32'(bus.rd_data), 32'(got));
`endif
    check_status("st");
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;

    // Reset state while reset is held
    #1 rst = 1'b0;
    #2;
    check("rst_count", 32'(bus.count), 0);
    check("rst_empty", 32'(bus.fifo_Empty), 1);
    check("rst_ae", 32'(bus.almost_empty), 1);
    check("rst_full", 32'(bus.fifo_Full), 0);
    check("rst_af", 32'(bus.almost_full), 0);
    check("rst_rd_valid", 32'(bus.rd_valid), 0);
    check("rst_ovf", 32'(bus.overflow), 0);
    check("rst_udf", 32'(bus.underflow), 0);
`ifndef SYNC_FIFO_FWFT_EN
    check("rst_rd_data", 32'(bus.rd_data), 0);
`endif
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    tick();

`ifdef SYNC_FIFO_FWFT_EN
    // Fall-through: word visible the cycle after it is written
    bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
    tick();
    bus.wr_en = 1'b0;
    check("fwft_valid", 32'(bus.rd_valid), 1);
    check("fwft_data", 32'(bus.rd_data), 32'h0000_00A5);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("fwft_pop_empty", 32'(bus.fifo_Empty), 1);
    check("fwft_pop_valid", 32'(bus.rd_valid), 0);
`endif

    // Fill with 0x00..0x59
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, N'(i), 1'b0);
      check("fill_af", 32'(bus.almost_full), (i >= 79) ? 1 : 0);
    end
    check("full_flag", 32'(bus.fifo_Full), 1);
    check("full_count", 32'(bus.count), 90);

    // 91st write: overflow, count unchanged
    drive(1'b1, 8'hEE, 1'b0);
    check("ovf_set", 32'(bus.overflow), 1);
    check("ovf_count", 32'(bus.count), 90);

    // Drain in order
    for (int i = 0; i < DEPTH; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      check("drain_head", 32'(bus.rd_data), i);
`endif
      drive(1'b0, '0, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
      check("drain_data", 32'(bus.rd_data), i);
`endif
    end
    check("drain_empty", 32'(bus.fifo_Empty), 1);
    check("drain_ae", 32'(bus.almost_empty), 1);
    check("ovf_sticky", 32'(bus.overflow), 1);
    drive(1'b0, '0, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
    check("rd_data_hold", 32'(bus.rd_data), 32'h59);
`endif

    // Extra read: underflow
    drive(1'b0, '0, 1'b1);
    check("udf_set", 32'(bus.underflow), 1);

    // Flush clears error bits
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_ovf", 32'(bus.overflow), 0);
    check("clr_udf", 32'(bus.underflow), 0);

    // Steady traffic at count=45 wraps both pointers
    for (int i = 0; i < 45; i++) drive(1'b1, N'(i * 7 + 3), 1'b0);
    for (int i = 0; i < 200; i++) begin
      drive(1'b1, N'(i * 13 + 1), 1'b1);
      check("wrap_count", 32'(bus.count), 45);
    end
    check("wrap_ovf", 32'(bus.overflow), 0);
    check("wrap_udf", 32'(bus.underflow), 0);

    // Full with simultaneous requests: read taken, write dropped
    for (int i = 0; i < 45; i++) drive(1'b1, N'(i + 100), 1'b0);
    check("full2_count", 32'(bus.count), 90);
    drive(1'b1, 8'hCC, 1'b1);
    check("fullrw_count", 32'(bus.count), 89);
    check("fullrw_ovf", 32'(bus.overflow), 1);
    for (int i = 0; i < 89; i++) drive(1'b0, '0, 1'b1);
    check("fullrw_drained", 32'(bus.fifo_Empty), 1);

    // Empty with simultaneous requests: write taken, read rejected
    clr = 1'b1;
    tick();
    clr = 1'b0;
    drive(1'b1, 8'h3C, 1'b1);
    check("emptyrw_count", 32'(bus.count), 1);
    check("emptyrw_udf", 32'(bus.underflow), 1);
`ifdef SYNC_FIFO_FWFT_EN
    check("emptyrw_head", 32'(bus.rd_data), 32'h3C);
`endif
    drive(1'b0, '0, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
    check("emptyrw_data", 32'(bus.rd_data), 32'h3C);
`endif

    // Flush at count=37 with a write in the same cycle
    for (int i = 0; i < 37; i++) drive(1'b1, N'(i + 1), 1'b0);
    check("pre_clr_count", 32'(bus.count), 37);
    clr = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'h77;
    tick();
    clr = 1'b0; bus.wr_en = 1'b0;
    exp_q.delete();
    check("clr_count", 32'(bus.count), 0);
    check("clr_empty", 32'(bus.fifo_Empty), 1);
    check("clr_ae", 32'(bus.almost_empty), 1);
    check("clr_udf2", 32'(bus.underflow), 0);
    check("clr_rd_valid", 32'(bus.rd_valid), 0);
    drive(1'b1, 8'h42, 1'b0);
    drive(1'b0, '0, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
    check("post_clr_data", 32'(bus.rd_data), 32'h42);
`endif

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 5; i++) drive(1'b1, N'(i + 8'h81), 1'b0);
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.wr_data = 8'h99;
    tick();
    #1 rst = 1'b0;
    #1;
    check("arst_count", 32'(bus.count), 0);
    check("arst_empty", 32'(bus.fifo_Empty), 1);
    check("arst_full", 32'(bus.fifo_Full), 0);
    check("arst_ae", 32'(bus.almost_empty), 1);
    check("arst_rd_valid", 32'(bus.rd_valid), 0);
`ifndef SYNC_FIFO_FWFT_EN
    check("arst_rd_data", 32'(bus.rd_data), 0);
`endif
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    exp_q.delete();
    @(negedge clk) rst = 1'b1;
    drive(1'b0, '0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised FIFO; successor to the dual-clock FIFO for same-domain buffering where CDC is not needed.
- Generalised over data width and arbitrary depth, including non-power-of-2 depths such as 90.
- Adds occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow errors and a synchronous flush.
- Optional first-word-fall-through (FWFT) read mode.

Parameters:
- N, 8, data width in bits (>=1)
- DEPTH, 90, number of entries (>=2, any integer, not restricted to power of 2)
- AF_LEVEL, 80, almost_full asserted when count >= AF_LEVEL (1..DEPTH)
- AE_LEVEL, 8, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- clr  input  1  synchronous flush, active-high
- wr_en  input  1  write request
- wr_data  input  N  write data
- rd_en  input  1  read request
- rd_data  output  N  read data
- rd_valid  output  1  rd_data holds a popped word (standard mode) / head valid (FWFT)
- fifo_Full  output  1  count == DEPTH
- fifo_Empty  output  1  count == 0
- almost_full  output  1  count >= AF_LEVEL
- almost_empty  output  1  count <= AE_LEVEL
- count  output  CW=$clog2(DEPTH+1)  current occupancy
- overflow  output  1  sticky: write attempted while full
- underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (rst=0, async): wr_ptr=rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=underflow=0; fifo_Empty=1, almost_empty=1, fifo_Full=0, almost_full=0. Memory contents are not reset.
- Pointers: width PW=$clog2(DEPTH). Increment wraps explicitly from DEPTH-1 to 0, never via natural binary overflow.
- Accept rules use registered flags:
  - wr_acc = wr_en & ~fifo_Full
  - rd_acc = rd_en & ~fifo_Empty
- Write: on wr_acc, mem[wr_ptr] <= wr_data and wr_ptr advances.
- Count update: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither accept.
- Full + simultaneous rd_en & wr_en: read accepted, write rejected; overflow is set, count becomes DEPTH-1.
- Empty + simultaneous: write accepted, read rejected; underflow is set, count becomes 1.
- Flags are registered, derived from next-state count in the same edge, so they are valid in the cycle after the causing edge with no extra lag.
- Standard mode (macro off): on rd_acc, rd_data <= mem[rd_ptr] and rd_ptr advances. rd_valid is 1 for exactly the next cycle (1-cycle read latency). rd_data holds its last value otherwise.
- overflow/underflow: set on wr_en&fifo_Full / rd_en&fifo_Empty; cleared only by rst or clr.
- clr=1: next edge gives pointers=0, count=0, flags to empty state, rd_valid=0, overflow=underflow=0. Any wr_en/rd_en in the same cycle is ignored. clr takes priority over everything except rst.
- Reset asserted mid-operation: immediate return to reset state; all stored data is considered lost.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN
- Defined:
  - rd_data = mem[rd_ptr] combinationally; rd_valid = ~fifo_Empty.
  - rd_en acts as a pop/acknowledge of the currently shown word.
  - Word written into an empty FIFO appears on rd_data in the cycle after the write edge.
  - Accept, count and error rules are unchanged.
- Undefined: standard 1-cycle registered read as above.

Decomposition:
- Package sync_fifo_pkg:
  - function clog2_min1(depth) returning max(1,$clog2(depth)) for pointer width
  - function cnt_w(depth) = $clog2(depth+1)
  - localparam defaults DEF_N=8, DEF_DEPTH=90
- Sub-module fifo_wrap_ptr:
  - parameters DEPTH, PW; ports clk, rst, clr, inc, ptr
  - wrapping increment counter, instantiated twice (write and read pointers)

Test Plan:
- N=8, DEPTH=90: reset, write 0x00..0x59 (90 words) -> fifo_Full=1, count=90, almost_full rises after the write making count=80. 91st write sets overflow=1, count stays 90.
- Read all 90 words -> data returned 0x00..0x59 in order with rd_valid one cycle after each rd_en. fifo_Empty=1 after last read, almost_empty=1 once count<=8. Extra rd_en sets underflow=1.
- Wrap: 200 cycles of continuous simultaneous wr/rd at count=45 -> count stays 45, pointers wrap 89->0, data order preserved, no error flags.
- Full + simultaneous wr/rd -> count=89, overflow=1, written word dropped. Empty + simultaneous -> count=1, underflow=1, word later read correctly.
- clr at count=37 with wr_en=1 -> next cycle count=0, fifo_Empty=1, errors cleared, write ignored. rst pulsed low mid-burst -> outputs immediately take reset values.
- SYNC_FIFO_FWFT_EN defined: write 0xA5 into empty FIFO -> rd_valid=1 and rd_data=0xA5 next cycle with no rd_en. rd_en pops it -> fifo_Empty=1 the following cycle.
